// File: rtl/decimal_entry.sv
// ============================================================================
// Module   : decimal_entry
// Purpose  : Keypad decimal-to-binary operand accumulator (x10 shift-add,
//            optional restoring divide-by-10 backspace when
//            DECIMAL_ENTRY_BACKSPACE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_entry #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       digit_count,
    output logic             overflow,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int AW = WIDTH + 4;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_add  = 2'd2;
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    localparam logic [1:0] c_div  = 2'd3;
    localparam logic [3:0] c_key_back = 4'd11;
    localparam int CW = $clog2(WIDTH + 1);
`endif

    localparam logic [3:0]    c_key_clear  = 4'd10;
    localparam logic [3:0]    c_key_enter  = 4'd12;
    localparam logic [3:0]    c_max_digits = 4'(MAX_DIGITS);
    localparam logic [AW-1:0] c_max_val    = {4'b0000, {WIDTH{1'b1}}};

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [3:0]    r_digit;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_mul;
    logic [AW-1:0] w_sum;
    logic          w_accept;
    logic          w_is_digit;
    logic          w_reject;
    logic          w_leading_zero;

`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    logic [WIDTH-1:0] r_quo;
    logic [3:0]       r_rem;
    logic [CW-1:0]    r_div_cnt;
    logic [4:0]       w_trial;
    logic             w_ge;
    logic [3:0]       w_rem_next;

    // One restoring step: bring down the next dividend bit, subtract 10 if it fits.
    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_trial >= 5'd10);
    assign w_rem_next = w_ge ? 4'(w_trial - 5'd10) : w_trial[3:0];
`endif

    assign w_accept       = key_valid && key_ready;
    assign w_is_digit     = (key_code <= 4'd9);
    assign w_mul          = ({4'b0000, value} << 3) + ({4'b0000, value} << 1);
    assign w_sum          = r_acc + AW'(r_digit);
    assign w_reject       = (digit_count == c_max_digits) || (w_sum > c_max_val);
    assign w_leading_zero = (value == '0) && (r_digit == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_accept && w_is_digit) begin
                    w_next_state = c_mul;
                end
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
                else if (w_accept && (key_code == c_key_back) && (digit_count != 4'd0)) begin
                    w_next_state = c_div;
                end
`endif
            end
            c_mul:   w_next_state = c_add;
            c_add:   w_next_state = c_idle;
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
            c_div: begin
                if (r_div_cnt == CW'(WIDTH)) begin
                    w_next_state = c_idle;
                end
            end
`endif
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        key_ready = (r_state == c_idle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value        <= '0;
            digit_count  <= 4'd0;
            overflow     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            r_digit      <= 4'd0;
            r_acc        <= '0;
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
            r_quo        <= '0;
            r_rem        <= 4'd0;
            r_div_cnt    <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            r_digit <= key_code;
                        end else if (key_code == c_key_clear) begin
                            value       <= '0;
                            digit_count <= 4'd0;
                            overflow    <= 1'b0;
                        end else if (key_code == c_key_enter) begin
                            result       <= value;
                            result_valid <= 1'b1;
                            value        <= '0;
                            digit_count  <= 4'd0;
                            overflow     <= 1'b0;
                        end
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
                        else if ((key_code == c_key_back) && (digit_count != 4'd0)) begin
                            r_quo     <= value;
                            r_rem     <= 4'd0;
                            r_div_cnt <= '0;
                        end
`endif
                    end
                end
                c_mul: begin
                    r_acc <= w_mul;
                end
                c_add: begin
                    // Reject before commit so a too-large sum never reaches value.
                    if (w_reject) begin
                        overflow <= 1'b1;
                    end else begin
                        value <= w_sum[WIDTH-1:0];
                        if (!w_leading_zero) begin
                            digit_count <= digit_count + 4'd1;
                        end
                    end
                end
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
                c_div: begin
                    if (r_div_cnt == CW'(WIDTH)) begin
                        value       <= r_quo;
                        digit_count <= digit_count - 4'd1;
                        overflow    <= 1'b0;
                    end else begin
                        r_quo     <= {r_quo[WIDTH-2:0], w_ge};
                        r_rem     <= w_rem_next;
                        r_div_cnt <= r_div_cnt + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decimal_entry.sv
// ============================================================================
// Module   : tb_decimal_entry
// Purpose  : Directed plus random key sequences for decimal_entry, checked
//            against an arithmetic model of the keypad operand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_entry;

    localparam int W  = 8;
    localparam int MD = 3;
`ifdef DECIMAL_ENTRY_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic [W-1:0] value;
    logic [3:0]   digit_count;
    logic         overflow;
    logic [W-1:0] result;
    logic         result_valid;

    decimal_entry #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .value        (value),
        .digit_count  (digit_count),
        .overflow     (overflow),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference operand state
    int mv = 0;
    int mc = 0;
    int mo = 0;
    int mr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit rv);
        chk({tag, " key_ready"},    32'(key_ready),    1);
        chk({tag, " value"},        32'(value),        mv);
        chk({tag, " digit_count"},  32'(digit_count),  mc);
        chk({tag, " overflow"},     32'(overflow),     mo);
        chk({tag, " result"},       32'(result),       mr);
        chk({tag, " result_valid"}, 32'(result_valid), 32'(rv));
    endtask

    // Applies one accepted key to the model; returns busy cycles and pulse flag.
    task automatic model_key(input int c, output int busy, output bit rv);
        int nv;
        busy = 0;
        rv   = 1'b0;
        if (c <= 9) begin
            busy = 2;
            nv = mv * 10 + c;
            if (mc == MD || nv > (1 << W) - 1) begin
                mo = 1;
            end else begin
                if (!(mv == 0 && c == 0)) mc++;
                mv = nv;
            end
        end else if (c == 10) begin
            mv = 0; mc = 0; mo = 0;
        end else if (c == 12) begin
            mr = mv; rv = 1'b1;
            mv = 0; mc = 0; mo = 0;
        end else if (c == 11 && BS_EN && mc > 0) begin
            busy = W + 1;
            mv = mv / 10; mc--; mo = 0;
        end
    endtask

    task automatic press(input int c, input string tag);
        int busy;
        bit rv;
        chk({tag, " ready before key"}, 32'(key_ready), 1);
        key_valid = 1'b1;
        key_code  = 4'(c);
        tick();
        key_valid = 1'b0;
        model_key(c, busy, rv);
        for (int k = 0; k < busy; k++) begin
            chk({tag, " busy"}, 32'(key_ready), 0);
            tick();
        end
        check_state(tag, rv);
    endtask

    task automatic model_reset();
        mv = 0; mc = 0; mo = 0; mr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int busy;
        bit rv;

        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        tick(); tick();
        model_reset();
        check_state("reset", 1'b0);
        rst = 1'b0;
        tick();

        press(1, "d1"); press(2, "d2"); press(3, "d3");
        chk("value 123", 32'(value), 123);
        press(12, "enter123");
        chk("result 123", 32'(result), 123);
        tick();
        chk("result_valid drops", 32'(result_valid), 0);

        press(2, "a2"); press(5, "a5"); press(6, "a6");
        chk("overflow 256", 32'(overflow), 1);
        chk("value kept 25", 32'(value), 25);
        press(10, "clear");

        press(0, "z0"); press(0, "z0b"); press(7, "z7");
        chk("leading zero count", 32'(digit_count), 1);
        press(9, "n9"); press(9, "n9b"); press(9, "n9c"); press(6, "n6");

        press(10, "clear2");
        press(1, "m1"); press(0, "m0"); press(0, "m0b"); press(5, "m5max");
        chk("max digits count", 32'(digit_count), 3);
        press(13, "ign13"); press(14, "ign14"); press(15, "ign15");
        press(11, "bs_or_ign");
        press(10, "clear3");
        press(11, "bs_at_zero");
        press(12, "enter0");

        // Reset in the middle of a multiply: partial result discarded.
        press(4, "pre4"); press(12, "enter4");
        key_valid = 1'b1; key_code = 4'd8;
        tick();
        key_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_state("rst mid-mul", 1'b0);

        if (BS_EN) begin
            press(1, "h1"); press(2, "h2"); press(3, "h3");
            // Backspace then keep presenting digit 5 throughout the divide.
            key_valid = 1'b1; key_code = 4'd11;
            tick();
            key_code = 4'd5;
            model_key(11, busy, rv);
            for (int k = 0; k < busy; k++) begin
                chk("held busy", 32'(key_ready), 0);
                tick();
            end
            check_state("held after bs", rv);
            chk("bs value 12", 32'(value), 12);
            tick();
            key_valid = 1'b0;
            model_key(5, busy, rv);
            for (int k = 0; k < busy; k++) begin
                chk("held digit busy", 32'(key_ready), 0);
                tick();
            end
            check_state("held digit", rv);

            press(12, "enter125");
            key_valid = 1'b1; key_code = 4'd11;
            press(7, "p7"); press(3, "p3");
            key_valid = 1'b1; key_code = 4'd11;
            tick();
            key_valid = 1'b0;
            tick(); tick(); tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_reset();
            check_state("rst mid-div", 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            c = int'($urandom_range(0, 19));
            if (c > 15) c = int'($urandom_range(0, 9));
            press(c, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
